id_ex_pipeline_reg: RTL and testbench

Decode-to-execute pipeline register for the five-stage RV32I core. It captures the control word from the main/ALU decoders and the operand and immediate data from the register file and extender at the end of the decode stage. It presents them as stable execute-stage signals. It also implements stall (hold), flush (bubble insertion) and decode-invalid squashing, and keeps a saturating bubble counter for the hazard-unit debug bus.

---
 rtl/id_ex_pipeline_reg.sv | 112 +++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register: captures the decoder control word and operand data,
// with stall hold, flush/invalid-decode bubble insertion and a saturating bubble counter.
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH_2    = 2,
  parameter int unsigned WIDTH_3    = 3,
  parameter int unsigned WIDTH_ALU  = 4,
  parameter int unsigned WIDTH_REG  = 5,
  parameter int unsigned WIDTH_CNT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  valid_d,
  input  logic                  reg_write_d,
  input  logic                  mem_write_d,
  input  logic                  alu_src_d,
  input  logic                  branch_d,
  input  logic                  jump_d,
  input  logic                  jump_src_d,
  input  logic [WIDTH_2-1:0]    result_src_d,
  input  logic [WIDTH_ALU-1:0]  alu_control_d,
  input  logic [WIDTH_3-1:0]    funct3_d,
  input  logic [DATA_WIDTH-1:0] rd1_d,
  input  logic [DATA_WIDTH-1:0] rd2_d,
  input  logic [DATA_WIDTH-1:0] pc_d,
  input  logic [DATA_WIDTH-1:0] imm_ext_d,
  input  logic [DATA_WIDTH-1:0] pc_plus4_d,
  input  logic [WIDTH_REG-1:0]  rs1_d,
  input  logic [WIDTH_REG-1:0]  rs2_d,
  input  logic [WIDTH_REG-1:0]  rd_d,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  alu_src_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic                  jump_src_e,
  output logic [WIDTH_2-1:0]    result_src_e,
  output logic [WIDTH_ALU-1:0]  alu_control_e,
  output logic [WIDTH_3-1:0]    funct3_e,
  output logic [DATA_WIDTH-1:0] rd1_e,
  output logic [DATA_WIDTH-1:0] rd2_e,
  output logic [DATA_WIDTH-1:0] pc_e,
  output logic [DATA_WIDTH-1:0] imm_ext_e,
  output logic [DATA_WIDTH-1:0] pc_plus4_e,
  output logic [WIDTH_REG-1:0]  rs1_e,
  output logic [WIDTH_REG-1:0]  rs2_e,
  output logic [WIDTH_REG-1:0]  rd_e,
  output logic [WIDTH_CNT-1:0]  bubble_count
);

  logic load_bubble;
  logic cnt_max;

  // A bubble is loaded on flush, or on a normal load of an invalid decode slot.
  assign load_bubble = flush_e | (~stall_e & ~valid_d);
  assign cnt_max     = (bubble_count == {WIDTH_CNT{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      valid_e       <= 1'b0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      alu_src_e     <= 1'b0;
      branch_e      <= 1'b0;
      jump_e        <= 1'b0;
      jump_src_e    <= 1'b0;
      result_src_e  <= '0;
      alu_control_e <= '0;
      funct3_e      <= '0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      imm_ext_e     <= '0;
      pc_plus4_e    <= '0;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
    end else if (!stall_e) begin
      valid_e       <= valid_d;
      reg_write_e   <= reg_write_d;
      mem_write_e   <= mem_write_d;
      alu_src_e     <= alu_src_d;
      branch_e      <= branch_d;
      jump_e        <= jump_d;
      jump_src_e    <= jump_src_d;
      result_src_e  <= result_src_d;
      alu_control_e <= alu_control_d;
      funct3_e      <= funct3_d;
      rd1_e         <= rd1_d;
      rd2_e         <= rd2_d;
      pc_e          <= pc_d;
      imm_ext_e     <= imm_ext_d;
      pc_plus4_e    <= pc_plus4_d;
      rs1_e         <= rs1_d;
      rs2_e         <= rs2_d;
      rd_e          <= rd_d;
    end
  end

  // Saturating count of bubbles loaded since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (load_bubble && !cnt_max) begin
      bubble_count <= bubble_count + WIDTH_CNT'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized and directed bench for id_ex_pipeline_reg against a behavioural pipeline-slot model.
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        jump_src;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst, stall_e, flush_e;
  slot_t din, obs, obs_sat;
  logic [15:0] bubble_count;
  logic [3:0]  bubble_count_sat;

  int n_tests = 0;
  int n_fail  = 0;

  slot_t exp_e;
  int    exp_cnt;
  int    exp_cnt_sat;

  always #5 clk = ~clk;

  id_ex_pipeline_reg u_dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(din.valid),
    .reg_write_d(din.reg_write), .mem_write_d(din.mem_write), .alu_src_d(din.alu_src),
    .branch_d(din.branch), .jump_d(din.jump), .jump_src_d(din.jump_src),
    .result_src_d(din.result_src), .alu_control_d(din.alu_control), .funct3_d(din.funct3),
    .rd1_d(din.rd1), .rd2_d(din.rd2), .pc_d(din.pc), .imm_ext_d(din.imm_ext),
    .pc_plus4_d(din.pc_plus4), .rs1_d(din.rs1), .rs2_d(din.rs2), .rd_d(din.rd),
    .valid_e(obs.valid), .reg_write_e(obs.reg_write), .mem_write_e(obs.mem_write),
    .alu_src_e(obs.alu_src), .branch_e(obs.branch), .jump_e(obs.jump), .jump_src_e(obs.jump_src),
    .result_src_e(obs.result_src), .alu_control_e(obs.alu_control), .funct3_e(obs.funct3),
    .rd1_e(obs.rd1), .rd2_e(obs.rd2), .pc_e(obs.pc), .imm_ext_e(obs.imm_ext),
    .pc_plus4_e(obs.pc_plus4), .rs1_e(obs.rs1), .rs2_e(obs.rs2), .rd_e(obs.rd),
    .bubble_count(bubble_count)
  );

  // Narrow-counter instance to reach saturation in a short run.
  id_ex_pipeline_reg #(.WIDTH_CNT(4)) u_dut_sat (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(din.valid),
    .reg_write_d(din.reg_write), .mem_write_d(din.mem_write), .alu_src_d(din.alu_src),
    .branch_d(din.branch), .jump_d(din.jump), .jump_src_d(din.jump_src),
    .result_src_d(din.result_src), .alu_control_d(din.alu_control), .funct3_d(din.funct3),
    .rd1_d(din.rd1), .rd2_d(din.rd2), .pc_d(din.pc), .imm_ext_d(din.imm_ext),
    .pc_plus4_d(din.pc_plus4), .rs1_d(din.rs1), .rs2_d(din.rs2), .rd_d(din.rd),
    .valid_e(obs_sat.valid), .reg_write_e(obs_sat.reg_write), .mem_write_e(obs_sat.mem_write),
    .alu_src_e(obs_sat.alu_src), .branch_e(obs_sat.branch), .jump_e(obs_sat.jump),
    .jump_src_e(obs_sat.jump_src), .result_src_e(obs_sat.result_src),
    .alu_control_e(obs_sat.alu_control), .funct3_e(obs_sat.funct3),
    .rd1_e(obs_sat.rd1), .rd2_e(obs_sat.rd2), .pc_e(obs_sat.pc), .imm_ext_e(obs_sat.imm_ext),
    .pc_plus4_e(obs_sat.pc_plus4), .rs1_e(obs_sat.rs1), .rs2_e(obs_sat.rs2), .rd_e(obs_sat.rd),
    .bubble_count(bubble_count_sat)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare just after the edge.
  task automatic step(input slot_t d, input logic r, input logic s, input logic f);
    din     = d;
    rst     = r;
    stall_e = s;
    flush_e = f;
    @(posedge clk);
    if (r) begin
      exp_e       = '0;
      exp_cnt     = 0;
      exp_cnt_sat = 0;
    end else if (f || (!s && !d.valid)) begin
      exp_e       = '0;
      exp_cnt     = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
      exp_cnt_sat = (exp_cnt_sat < 15) ? exp_cnt_sat + 1 : 15;
    end else if (!s) begin
      exp_e = d;
    end
    #1;
    check("slot", 256'(obs), 256'(exp_e));
    check("slot_sat", 256'(obs_sat), 256'(exp_e));
    check("bubble_count", 256'(bubble_count), 256'(exp_cnt));
    check("bubble_count_sat", 256'(bubble_count_sat), 256'(exp_cnt_sat));
    @(negedge clk);
  endtask

  function automatic slot_t rand_slot();
    logic [223:0] raw;
    raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return slot_t'(raw[$bits(slot_t)-1:0]);
  endfunction

  initial begin
    slot_t d;
    int    cnt_before;
    exp_e       = '0;
    exp_cnt     = 0;
    exp_cnt_sat = 0;
    din = '0; rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    @(negedge clk);

    // Reset with every input at ones, then first load after release.
    d = '1;
    step(d, 1'b1, 1'b1, 1'b1);
    step(d, 1'b1, 1'b0, 1'b0);
    check("reset_valid_e", 256'(obs.valid), 256'(0));
    check("reset_count", 256'(bubble_count), 256'(0));
    step(d, 1'b0, 1'b0, 1'b0);
    check("first_load_pc", 256'(obs.pc), 256'(32'hFFFF_FFFF));

    // Pass-through.
    d = '0;
    d.valid = 1'b1; d.rd1 = 32'h0000_1234; d.imm_ext = 32'hFFFF_FFFC;
    d.rd = 5'd5; d.reg_write = 1'b1; d.alu_control = 4'b0010;
    step(d, 1'b0, 1'b0, 1'b0);
    check("pass_rd1", 256'(obs.rd1), 256'(32'h0000_1234));
    check("pass_imm", 256'(obs.imm_ext), 256'(32'hFFFF_FFFC));
    check("pass_rd", 256'(obs.rd), 256'(5));
    check("pass_alu", 256'(obs.alu_control), 256'(4'b0010));
    check("pass_valid", 256'({obs.valid, obs.reg_write}), 256'(2'b11));

    // Multi-cycle stall holds, release loads the latest value.
    d = rand_slot(); d.valid = 1'b1; d.pc = 32'h100;
    step(d, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      d.pc = 32'h100 + 32'(4 * i);
      step(d, 1'b0, 1'b1, 1'b0);
      check("stall_pc", 256'(obs.pc), 256'(32'h100));
    end
    step(d, 1'b0, 1'b0, 1'b0);
    check("release_pc", 256'(obs.pc), 256'(32'h10C));

    // Flush beats stall.
    d = rand_slot(); d.valid = 1'b1; d.reg_write = 1'b1; d.mem_write = 1'b1;
    step(d, 1'b0, 1'b0, 1'b0);
    cnt_before = exp_cnt;
    step(d, 1'b0, 1'b1, 1'b1);
    check("flush_ctl", 256'({obs.valid, obs.reg_write, obs.mem_write}), 256'(0));
    check("flush_count", 256'(bubble_count), 256'(cnt_before + 1));
    // Bubble persists while the stall continues.
    step(d, 1'b0, 1'b1, 1'b0);
    check("flush_hold_count", 256'(bubble_count), 256'(cnt_before + 1));

    // Invalid decode squashes branch/jump.
    d = rand_slot(); d.valid = 1'b0; d.branch = 1'b1; d.jump = 1'b1;
    cnt_before = exp_cnt;
    step(d, 1'b0, 1'b0, 1'b0);
    check("invalid_ctl", 256'({obs.valid, obs.branch, obs.jump}), 256'(0));
    check("invalid_count", 256'(bubble_count), 256'(cnt_before + 1));

    // Saturation of the narrow counter.
    for (int i = 0; i < 20; i++) step(rand_slot(), 1'b0, 1'b0, 1'b1);
    check("sat_count", 256'(bubble_count_sat), 256'(15));

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      d = rand_slot();
      d.valid = ($urandom_range(0, 9) < 8);
      step(d, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
